// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display block.
package score_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_e;

  localparam int          NUM_DIGITS = 5;
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;
  localparam logic [6:0]  SEG_H      = 7'b0001001;

endpackage : score_display_pkg

// File: rtl/score_display_seven_seg_decoder.sv
// BCD digit to active-low seven-segment pattern, bit order gfedcba.
module seven_seg_decoder (
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Pure lookup; codes 10..15 never occur from a valid conversion and show blank.
  always_comb begin
    seg_o = 7'h7F;
    unique case (bcd_i)
      4'd0: seg_o = 7'b1000000;
      4'd1: seg_o = 7'b1111001;
      4'd2: seg_o = 7'b0100100;
      4'd3: seg_o = 7'b0110000;
      4'd4: seg_o = 7'b0011001;
      4'd5: seg_o = 7'b0010010;
      4'd6: seg_o = 7'b0000010;
      4'd7: seg_o = 7'b1111000;
      4'd8: seg_o = 7'b0000000;
      4'd9: seg_o = 7'b0010000;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule : seven_seg_decoder

// File: rtl/score_display.sv
// Live/high score to five blanked seven-segment digits plus a mode marker,
// using a sequential double-dabble binary-to-BCD converter.
module score_display
  import score_display_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SHIFT_CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] score,
  input  logic             show_high,
  output logic [WIDTH-1:0] high_score,
  output logic             busy,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1,
  output logic [6:0]       hex2,
  output logic [6:0]       hex3,
  output logic [6:0]       hex4,
  output logic [6:0]       hex5,
  output state_e           dbg_state_o
);

  localparam int BCD_W = 4 * NUM_DIGITS;

  // Handshake note: there is no valid/ready pair here. The converter samples
  // src only in IDLE; anything that changes while busy is picked up by the
  // IDLE re-compare after the current conversion lands on the display.

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       bin_q, bin_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic [BCD_W-1:0]       bcd_adj;
  logic [SHIFT_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]       last_val_q, last_val_d;
  logic                   last_mode_q, last_mode_d;
  logic [BCD_W-1:0]       disp_bcd_q, disp_bcd_d;
  logic                   disp_mode_q, disp_mode_d;
  logic [WIDTH-1:0]       high_q;
  logic [WIDTH-1:0]       src;

  assign src         = show_high ? high_q : score;
  assign high_score  = high_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

  // High-score tracker: follows the running maximum of score, independent of the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      high_q <= '0;
    end else if (score > high_q) begin
      high_q <= score;
    end
  end

  // Per-nibble add-3 ahead of each shift; no carry crosses nibbles.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  // FSM next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    last_val_d  = last_val_q;
    last_mode_d = last_mode_q;
    disp_bcd_d  = disp_bcd_q;
    disp_mode_d = disp_mode_q;
    unique case (state_q)
      IDLE: begin
        if ((src != last_val_q) || (show_high != last_mode_q)) begin
          bin_d       = src;
          bcd_d       = '0;
          cnt_d       = '0;
          last_val_d  = src;
          last_mode_d = show_high;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == SHIFT_CNT_W'(WIDTH - 1)) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        disp_bcd_d  = bcd_q;
        disp_mode_d = last_mode_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      last_val_q  <= '0;
      last_mode_q <= 1'b0;
      disp_bcd_q  <= '0;
      disp_mode_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      last_val_q  <= last_val_d;
      last_mode_q <= last_mode_d;
      disp_bcd_q  <= disp_bcd_d;
      disp_mode_q <= disp_mode_d;
    end
  end

  logic [6:0] dec_seg [NUM_DIGITS];
  logic [6:0] hex_arr [NUM_DIGITS];
  logic       seen_nz;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seven_seg_decoder u_dec (
      .bcd_i (disp_bcd_q[g*4 +: 4]),
      .seg_o (dec_seg[g])
    );
  end

  // Leading-zero blanking from the top digit down; units digit always shown.
  always_comb begin
    seen_nz = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (disp_bcd_q[i*4 +: 4] != 4'd0) begin
        seen_nz = 1'b1;
      end
      hex_arr[i] = (seen_nz || (i == 0)) ? dec_seg[i] : SEG_BLANK;
    end
  end

  assign hex0 = hex_arr[0];
  assign hex1 = hex_arr[1];
  assign hex2 = hex_arr[2];
  assign hex3 = hex_arr[3];
  assign hex4 = hex_arr[4];
  assign hex5 = disp_mode_q ? SEG_H : SEG_BLANK;

endmodule : score_display

// File: tb/tb_score_display.sv
// Directed and randomized checks of score_display against a decimal reference model.
module tb_score_display;
  import score_display_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] score;
  logic        show_high;
  logic [15:0] high_score;
  logic        busy;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  state_e      dbg_state;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];
  logic [15:0] model_high;
  logic [6:0]  seg_tab [10];

  score_display dut (
    .clk         (clk),
    .reset       (reset),
    .score       (score),
    .show_high   (show_high),
    .high_score  (high_score),
    .busy        (busy),
    .hex0        (hex0),
    .hex1        (hex1),
    .hex2        (hex2),
    .hex3        (hex3),
    .hex4        (hex4),
    .hex5        (hex5),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
  end

  // Reference: decimal digit idx of value via division, blanked above the leading digit.
  function automatic logic [6:0] model_seg(input int value, input int idx);
    int p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (idx > 0 && value < p) return 7'h7F;
    return seg_tab[(value / p) % 10];
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_display(input string tag, input int value, input logic mode);
    check({tag, ".hex0"}, {9'd0, hex0}, {9'd0, model_seg(value, 0)});
    check({tag, ".hex1"}, {9'd0, hex1}, {9'd0, model_seg(value, 1)});
    check({tag, ".hex2"}, {9'd0, hex2}, {9'd0, model_seg(value, 2)});
    check({tag, ".hex3"}, {9'd0, hex3}, {9'd0, model_seg(value, 3)});
    check({tag, ".hex4"}, {9'd0, hex4}, {9'd0, model_seg(value, 4)});
    check({tag, ".hex5"}, {9'd0, hex5}, {9'd0, (mode ? 7'b0001001 : 7'h7F)});
  endtask

  // Driver tasks: inputs change at negedge, outputs sampled 1 time unit after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] s, input logic sh);
    @(negedge clk);
    score     = s;
    show_high = sh;
    if (s > model_high) model_high = s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    score = 16'd0;
    show_high = 1'b0;
    model_high = 16'd0;
    step();
    step();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic settle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin step(); n++; end
    check({tag, ".settle"}, {15'd0, (n < 200)}, 16'd1);
  endtask

  initial begin
    logic [15:0] v, exp_v;
    logic        m;
    reset = 1'b1; score = 16'd0; show_high = 1'b0; model_high = 16'd0;

    // Reset state and idle quiet period
    do_reset();
    #1;
    check("rst.busy", {15'd0, busy}, 16'd0);
    check("rst.high", high_score, 16'd0);
    check_display("rst", 0, 1'b0);
    begin
      int busy_seen = 0;
      for (int i = 0; i < 50; i++) begin step(); if (busy !== 1'b0) busy_seen++; end
      check("rst.quiet", busy_seen[15:0], 16'd0);
    end

    // 12345 with exact latency: busy after edges k..k+16, display after k+17
    drive(16'd12345, 1'b0);
    for (int i = 0; i <= 16; i++) begin
      step();
      check($sformatf("lat.busy%0d", i), {15'd0, busy}, 16'd1);
    end
    check("lat.old_hex0", {9'd0, hex0}, {9'd0, model_seg(0, 0)});
    step();
    check("lat.idle", {15'd0, busy}, 16'd0);
    check_display("d12345", 12345, 1'b0);

    // Maximum value
    drive(16'd65535, 1'b0);
    for (int i = 0; i < 18; i++) step();
    check("max.busy", {15'd0, busy}, 16'd0);
    check_display("d65535", 65535, 1'b0);
    check("max.high", high_score, 16'd65535);

    // High score tracking and mode marker
    do_reset();
    drive(16'd50, 1'b0);
    step(); step();
    settle("hs50");
    drive(16'd20, 1'b0);
    step(); step();
    settle("hs20");
    check("hs.high", high_score, 16'd50);
    check_display("hs.live", 20, 1'b0);
    drive(16'd20, 1'b1);
    step(); step();
    settle("hs.sel");
    check_display("hs.show", 50, 1'b1);

    // Change mid-conversion: 100 loaded at k, 205 before k+5
    do_reset();
    drive(16'd100, 1'b0);
    for (int i = 0; i < 5; i++) step();
    drive(16'd205, 1'b0);
    for (int i = 5; i < 17; i++) step();
    check("b2b.mid_busy", {15'd0, busy}, 16'd1);
    step();
    check("b2b.idle", {15'd0, busy}, 16'd0);
    check_display("b2b.first", 100, 1'b0);
    step();
    check("b2b.reload", {15'd0, busy}, 16'd1);
    for (int i = 19; i <= 35; i++) step();
    check("b2b.done", {15'd0, busy}, 16'd0);
    check_display("b2b.second", 205, 1'b0);

    // Reset in the middle of a conversion
    do_reset();
    drive(16'd999, 1'b0);
    for (int i = 0; i < 8; i++) step();
    @(negedge clk);
    reset = 1'b1;
    step();
    check("abort.busy", {15'd0, busy}, 16'd0);
    check("abort.high", high_score, 16'd0);
    check_display("abort", 0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    score = 16'd0;
    model_high = 16'd0;
    step();
    check("abort.stay", {15'd0, busy}, 16'd0);

    // Randomized: each applied source value goes into the scoreboard queue
    do_reset();
    for (int t = 0; t < 25; t++) begin
      v = 16'($urandom_range(0, 65535));
      if (t % 5 == 0) v = 16'($urandom_range(0, 120));
      m = 1'($urandom_range(0, 1));
      drive(v, m);
      exp_q.push_back(m ? ((v > model_high) ? v : model_high) : v);
      for (int i = 0; i < 45; i++) step();
      exp_v = exp_q.pop_front();
      check($sformatf("rnd%0d.busy", t), {15'd0, busy}, 16'd0);
      check($sformatf("rnd%0d.high", t), high_score, model_high);
      check_display($sformatf("rnd%0d", t), int'(exp_v), m);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_score_display
